hazard_sched: RTL and testbench

HAZARD_SCHED -- requirements
Module: hazard_sched

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/haz_track_pipe.sv | 25 ++
 rtl/hazard_sched.sv | 123 ++++++++++++
 tb/tb_hazard_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scheduler: stall/flush cause codes
// and the record carried down the tracking pipe for each issued instruction.
package hazard_pkg;

  // Field widths are fixed at the supported maximum so one record type serves every parameterisation.
  localparam int MAX_RW     = 8;
  localparam int MAX_ADDR_W = 32;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_REG   = 2'b01;
  localparam logic [1:0] CAUSE_MEM   = 2'b10;
  localparam logic [1:0] CAUSE_FLUSH = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [MAX_RW-1:0]     rd;
    logic                  wr_en;
    logic                  is_load;
    logic                  mem_en;
    logic                  mem_wr;
    logic [MAX_ADDR_W-1:0] mem_addr;
  } track_entry_t;

  localparam track_entry_t BUBBLE = '0;

  // True when a pending register write feeds one of the decode sources.
  function automatic logic reg_match(input track_entry_t e,
                                     input logic [MAX_RW-1:0] rs, input logic rs_used,
                                     input logic [MAX_RW-1:0] rt, input logic rt_used);
    return e.valid && e.wr_en &&
           ((rs_used && (e.rd == rs)) || (rt_used && (e.rd == rt)));
  endfunction

endpackage

// File: rtl/haz_track_pipe.sv
// Shift register of in-flight instruction records; entry 0 is the youngest,
// the oldest falls off the end every cycle.
module haz_track_pipe
  import hazard_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  track_entry_t             push,
  output track_entry_t [DEPTH-1:0] entries
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries <= '0;
    end else begin
      entries[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        entries[i] <= entries[i-1];
      end
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// Decode-stage interlock: compares the decode instruction with the tracked
// downstream stages and issues, stalls, or squashes it after a control transfer.
module hazard_sched
  import hazard_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int PIPE_DEPTH = 4,
  parameter int ADDR_W     = 16,
  parameter int BR_FLUSH   = 1,
  parameter int FWD_EN     = 0,
  localparam int RW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [RW-1:0]     id_rs,
  input  logic [RW-1:0]     id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [RW-1:0]     id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              id_mem_en,
  input  logic              id_mem_wr,
  input  logic [ADDR_W-1:0] id_mem_addr,
  input  logic              id_ctrl_xfer,
  output logic              nop,
  output logic              pc_stall,
  output logic [1:0]        cause
);

  track_entry_t [PIPE_DEPTH-1:0] entries;
  track_entry_t                  push;
  logic [1:0]                    flush_cnt;
  logic                          flush_active;
  logic                          reg_haz;
  logic                          mem_haz;
  logic                          issue;
  logic [MAX_RW-1:0]             rs_x;
  logic [MAX_RW-1:0]             rt_x;
  logic [MAX_ADDR_W-1:0]         addr_x;

  assign rs_x         = MAX_RW'(id_rs);
  assign rt_x         = MAX_RW'(id_rt);
  assign addr_x       = MAX_ADDR_W'(id_mem_addr);
  assign flush_active = (flush_cnt != 2'd0);

  haz_track_pipe #(.DEPTH(PIPE_DEPTH)) u_track (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .entries (entries)
  );

  // With forwarding, only a load still in the youngest stage cannot be bypassed.
  always_comb begin
    reg_haz = 1'b0;
    if (id_valid) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        if ((FWD_EN == 0) || ((i == 0) && entries[i].is_load)) begin
          if (reg_match(entries[i], rs_x, id_rs_used, rt_x, id_rt_used)) reg_haz = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_haz = 1'b0;
    if (id_valid && id_mem_en) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        if (entries[i].valid && entries[i].mem_en && (entries[i].mem_addr == addr_x)) begin
          if (FWD_EN == 0) mem_haz = 1'b1;
          else if (!id_mem_wr && entries[i].mem_wr) mem_haz = 1'b1;
        end
      end
    end
  end

  // Flush outranks hazards; outputs stay quiet throughout reset.
  always_comb begin
    nop      = 1'b0;
    pc_stall = 1'b0;
    cause    = CAUSE_NONE;
    issue    = 1'b0;
    if (rst) begin
      if (flush_active) begin
        nop   = 1'b1;
        cause = CAUSE_FLUSH;
      end else if (reg_haz || mem_haz) begin
        nop      = 1'b1;
        pc_stall = 1'b1;
        cause    = reg_haz ? CAUSE_REG : CAUSE_MEM;
      end else begin
        issue = id_valid;
      end
    end
  end

  always_comb begin
    push = BUBBLE;
    if (issue) begin
      push.valid    = 1'b1;
      push.rd       = MAX_RW'(id_rd);
      push.wr_en    = id_wr_en;
      push.is_load  = id_is_load;
      push.mem_en   = id_mem_en;
      push.mem_wr   = id_mem_wr;
      push.mem_addr = addr_x;
    end
  end

  // The counter only loads when the transfer really issues, never while it is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt <= 2'd0;
    end else if (flush_active) begin
      flush_cnt <= flush_cnt - 2'd1;
    end else if (issue && id_ctrl_xfer) begin
      flush_cnt <= 2'(BR_FLUSH);
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: one default instance and one with
// forwarding and a two-cycle branch squash, driven from shared decode inputs.
module tb_hazard_sched;

  localparam logic [3:0] OK  = 4'b0000;
  localparam logic [3:0] RAW = 4'b1101;
  localparam logic [3:0] MEM = 4'b1110;
  localparam logic [3:0] FLS = 4'b1011;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic        id_rs_used, id_rt_used;
  logic        id_wr_en, id_is_load, id_mem_en, id_mem_wr;
  logic [15:0] id_mem_addr;
  logic        id_ctrl_xfer;

  logic       nop_a, pc_stall_a, nop_b, pc_stall_b;
  logic [1:0] cause_a, cause_b;

  logic [3:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  hazard_sched u_def (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_mem_en(id_mem_en), .id_mem_wr(id_mem_wr),
    .id_mem_addr(id_mem_addr), .id_ctrl_xfer(id_ctrl_xfer),
    .nop(nop_a), .pc_stall(pc_stall_a), .cause(cause_a)
  );

  hazard_sched #(.FWD_EN(1), .BR_FLUSH(2)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_mem_en(id_mem_en), .id_mem_wr(id_mem_wr),
    .id_mem_addr(id_mem_addr), .id_ctrl_xfer(id_ctrl_xfer),
    .nop(nop_b), .pc_stall(pc_stall_b), .cause(cause_b)
  );

  task automatic compare(input string tag, input bit sel);
    logic [3:0] obs;
    logic [3:0] exp;
    exp = exp_q.pop_front();
    obs = sel ? {nop_b, pc_stall_b, cause_b} : {nop_a, pc_stall_a, cause_a};
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed nop/stall/cause=%b expected %b", tag, obs, exp);
  endtask

  task automatic check_now(input string tag, input bit sel, input logic [3:0] exp);
    exp_q.push_back(exp);
    compare(tag, sel);
  endtask

  // Check this cycle's outputs mid-cycle, then step past the rising edge.
  task automatic cycle(input string tag, input bit sel, input logic [3:0] exp);
    exp_q.push_back(exp);
    @(negedge clk);
    compare(tag, sel);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [2:0] rs, input logic rsu,
                           input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                           input logic we, input logic ld, input logic me, input logic mw,
                           input logic [15:0] a, input logic cx);
    id_valid = v;  id_rs = rs;  id_rs_used = rsu;  id_rt = rt;  id_rt_used = rtu;
    id_rd = rd;  id_wr_en = we;  id_is_load = ld;  id_mem_en = me;  id_mem_wr = mw;
    id_mem_addr = a;  id_ctrl_xfer = cx;
  endtask

  task automatic set_alu(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
    set_instr(1, rs, 1, rt, 1, rd, 1, 0, 0, 0, 16'($urandom_range(0, 16'hffff)), 0);
  endtask

  task automatic set_load(input logic [2:0] rd, input logic [2:0] rs, input logic [15:0] a);
    set_instr(1, rs, 1, 3'd0, 0, rd, 1, 1, 1, 0, a, 0);
  endtask

  task automatic set_store(input logic [2:0] rs, input logic [2:0] rt, input logic [15:0] a);
    set_instr(1, rs, 1, rt, 1, 3'd0, 0, 0, 1, 1, a, 0);
  endtask

  task automatic set_branch(input logic [2:0] rs);
    set_instr(1, rs, 1, 3'd0, 0, 3'd0, 0, 0, 0, 0, 16'($urandom_range(0, 16'hffff)), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset: outputs held low even with a live instruction in decode.
    rst = 1'b0;
    set_alu(3'd3, 3'd3, 3'd3);
    @(negedge clk);
    check_now("reset_def", 0, OK);
    check_now("reset_fwd", 1, OK);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Default build: write r3 then read r3 stalls four cycles.
    set_alu(3'd3, 3'd1, 3'd2);
    cycle("wr_r3_issue", 0, OK);
    set_alu(3'd4, 3'd3, 3'd5);
    for (int k = 0; k < 4; k++) cycle("raw_stall", 0, RAW);
    cycle("raw_release", 0, OK);

    // Unused rt matching a pending rd, and an invalid slot, raise nothing.
    set_instr(1, 3'd1, 1, 3'd4, 0, 3'd6, 1, 0, 0, 0, 16'h0, 0);
    cycle("rt_unused", 0, OK);
    set_instr(0, 3'd6, 1, 3'd6, 1, 3'd7, 1, 0, 0, 0, 16'($urandom_range(0, 16'hffff)), 0);
    cycle("invalid_slot", 0, OK);
    set_alu(3'd5, 3'd7, 3'd7);
    cycle("bubble_pushed", 0, OK);

    // Branch stalled on r5: counter must not load until it issues.
    set_branch(3'd5);
    for (int k = 0; k < 4; k++) cycle("br_stall", 0, RAW);
    cycle("br_issue", 0, OK);
    set_alu(3'd1, 3'd0, 3'd0);
    cycle("br_flush1", 0, FLS);
    cycle("post_flush", 0, OK);

    // Reset during the second stall cycle aborts the stall.
    set_alu(3'd3, 3'd0, 3'd0);
    cycle("wr_r3_again", 0, OK);
    set_alu(3'd2, 3'd3, 3'd0);
    cycle("stall1", 0, RAW);
    check_now("stall2", 0, RAW);
    #1 rst = 1'b0;
    #1;
    check_now("mid_rst_def", 0, OK);
    check_now("mid_rst_fwd", 1, OK);
    #1 rst = 1'b1;
    cycle("post_rst_issue", 0, OK);

    // Fresh start for the forwarding instance.
    rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    set_load(3'd2, 3'd1, 16'h0010);
    cycle("ld_r2", 1, OK);
    set_alu(3'd5, 3'd2, 3'd0);
    cycle("load_use", 1, RAW);
    cycle("load_use_rel", 1, OK);
    set_alu(3'd2, 3'd1, 3'd1);
    cycle("alu_r2", 1, OK);
    set_alu(3'd6, 3'd2, 3'd1);
    cycle("alu_use_fwd", 1, OK);

    // Store 0x0040: load from 0x0042 passes, load from 0x0040 waits.
    set_store(3'd1, 3'd2, 16'h0040);
    cycle("st_40", 1, OK);
    set_load(3'd3, 3'd1, 16'h0042);
    cycle("ld_42", 1, OK);
    set_load(3'd7, 3'd1, 16'h0040);
    for (int k = 0; k < 3; k++) cycle("mem_raw", 1, MEM);
    cycle("mem_release", 1, OK);

    // Two-cycle squash hides a memory conflict, which then stalls normally.
    set_store(3'd1, 3'd1, 16'h0080);
    cycle("st_80", 1, OK);
    set_branch(3'd1);
    cycle("br2_issue", 1, OK);
    set_load(3'd4, 3'd1, 16'h0080);
    cycle("flush_a", 1, FLS);
    cycle("flush_b", 1, FLS);
    cycle("post_flush_st", 1, MEM);
    cycle("post_flush_go", 1, OK);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
